// File: rtl/cnn_pkg.sv
// Shared constants for the CNN datapath and the input loader state encoding.
package cnn_pkg;

    localparam int DATA_X      = 28;
    localparam int DATA_Y      = 28;
    localparam int DATA_SIZE   = 8;
    localparam int WEIGHT_X    = 5;
    localparam int WEIGHT_Y    = 5;
    localparam int WEIGHT_SIZE = 8;
    localparam int CONV_X      = DATA_X - WEIGHT_X + 1;
    localparam int CONV_Y      = DATA_Y - WEIGHT_Y + 1;
    // Full-precision accumulator width for one WEIGHT_X x WEIGHT_Y window
    localparam int CONV_SIZE   = DATA_SIZE + WEIGHT_SIZE + $clog2(WEIGHT_X * WEIGHT_Y);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/pix_addr_counter.sv
// Raster-order row/column address counter for the frame buffer write port.
module pix_addr_counter #(
    parameter  int ROWS  = 28,
    parameter  int COLS  = 28,
    localparam int ROW_W = $clog2(ROWS),
    localparam int COL_W = $clog2(COLS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             is_last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_wrap;
    logic             row_wrap;

    assign col_wrap  = (col_q == COL_W'(COLS - 1));
    assign row_wrap  = (row_q == ROW_W'(ROWS - 1));
    assign is_last_o = col_wrap & row_wrap;

    // Clear takes priority; incrementing past the last pixel returns to the origin
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/conv_data_loader.sv
// Assembles a raster pixel stream into a frame buffer, runs one convolution on it
// through the conv_enable/conv_done handshake, then rearms for the next frame.
module conv_data_loader
    import cnn_pkg::*;
#(
    parameter int CONV_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pix_valid_i,
    output logic                 pix_ready_o,
    input  logic [DATA_SIZE-1:0] pix_data_i,
    input  logic                 pix_last_i,
    output logic [DATA_SIZE-1:0] data_o [DATA_X][DATA_Y],
    output logic                 conv_enable_o,
    input  logic                 conv_done_i,
    output logic                 frame_done_o,
    output logic                 frame_err_o,
    input  logic                 err_clr_i,
    output logic                 busy_o
);

    localparam int ROW_W = $clog2(DATA_X);
    localparam int COL_W = $clog2(DATA_Y);
    localparam int TMR_W = $clog2(CONV_TIMEOUT + 1);

    loader_state_e        state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 conv_enable_q, conv_enable_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_SIZE-1:0] data_q [DATA_X][DATA_Y];

    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 is_last;
    logic                 xfer;
    logic                 pix_wr;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic                 set_err;
    logic                 timeout_hit;

    pix_addr_counter #(
        .ROWS (DATA_X),
        .COLS (DATA_Y)
    ) u_addr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (cnt_inc),
        .clear_i   (cnt_clr),
        .row_o     (row),
        .col_o     (col),
        .is_last_o (is_last)
    );

    assign pix_ready_o = (state_q == LOAD);
    assign xfer        = pix_valid_i & pix_ready_o;
    assign timeout_hit = (timer_q == TMR_W'(CONV_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        pix_wr  = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (xfer) begin
                    // A premature pix_last drops that pixel and resynchronises to the origin
                    if (pix_last_i && !is_last) begin
                        cnt_clr = 1'b1;
                        set_err = 1'b1;
                    end else begin
                        pix_wr  = 1'b1;
                        cnt_inc = 1'b1;
                        if (is_last) begin
                            state_d = CONV;
                            set_err = ~pix_last_i;
                        end
                    end
                end
            end
            CONV: begin
                // conv_done wins over a timeout landing on the same edge
                if (conv_done_i) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = LOAD;
                    set_err = 1'b1;
                end
            end
            DONE: state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        timer_d       = '0;
        conv_enable_d = (state_d == CONV);
        frame_done_d  = (state_d == DONE);
        frame_err_d   = set_err | (frame_err_q & ~err_clr_i);
        if (state_q == CONV && state_d == CONV) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= LOAD;
            timer_q       <= '0;
            conv_enable_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            conv_enable_q <= conv_enable_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Writes only happen in LOAD, so the buffer is frozen while conv_layer reads it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DATA_X; i++) begin
                for (int j = 0; j < DATA_Y; j++) begin
                    data_q[i][j] <= '0;
                end
            end
        end else if (pix_wr) begin
            data_q[row][col] <= pix_data_i;
        end
    end

    assign data_o        = data_q;
    assign conv_enable_o = conv_enable_q;
    assign frame_done_o  = frame_done_q;
    assign frame_err_o   = frame_err_q;
    assign busy_o        = (state_q != LOAD) | (row != '0) | (col != '0);

endmodule

// File: tb/tb_conv_data_loader.sv
// Directed bench for conv_data_loader: framing, handshake, timeout and reset behaviour.
module tb_conv_data_loader;

    localparam int DX  = 28;
    localparam int DY  = 28;
    localparam int NPX = DX * DY;
    localparam int TMO = 16;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_last  = 1'b0;
    logic       conv_done = 1'b0;
    logic       err_clr   = 1'b0;
    logic [7:0] pix_data  = 8'h00;
    logic       pix_ready;
    logic       conv_enable;
    logic       frame_done;
    logic       frame_err;
    logic       busy;
    logic [7:0] dut_data [DX][DY];

    int total  = 0;
    int bad    = 0;
    int ce_cnt = 0;
    int fd_cnt = 0;
    bit stall_err = 1'b0;

    always #5 clk = ~clk;

    // Count cycles with conv_enable / frame_done high, sampled mid-cycle
    always @(negedge clk) begin
        ce_cnt <= ce_cnt + ((conv_enable === 1'b1) ? 1 : 0);
        fd_cnt <= fd_cnt + ((frame_done === 1'b1) ? 1 : 0);
    end

    conv_data_loader #(
        .CONV_TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pix_valid_i   (pix_valid),
        .pix_ready_o   (pix_ready),
        .pix_data_i    (pix_data),
        .pix_last_i    (pix_last),
        .data_o        (dut_data),
        .conv_enable_o (conv_enable),
        .conv_done_i   (conv_done),
        .frame_done_o  (frame_done),
        .frame_err_o   (frame_err),
        .err_clr_i     (err_clr),
        .busy_o        (busy)
    );

    function automatic logic [7:0] pixfn(input int pat, input int r, input int c);
        int t;
        case (pat)
            0:       t = r + c;
            1:       t = 3 * r + 5 * c + 7;
            2:       t = 255 - r - c;
            default: t = 0;
        endcase
        return t[7:0];
    endfunction

    function automatic int buf_errs(input int pat, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) begin
            if (dut_data[k / DY][k % DY] !== pixfn(pat, k / DY, k % DY)) n++;
        end
        return n;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge
    task automatic send_px(input logic [7:0] d, input logic last);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        for (int n = 0; n < 64; n++) begin
            if (pix_ready === 1'b1) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        stall_err = 1'b1;
    endtask

    task automatic send_frame(input int pat, input int npx, input int last_idx, input bit rnd);
        for (int k = 0; k < npx; k++) begin
            if (rnd && $urandom_range(0, 1) == 1) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            send_px(pixfn(pat, k / DY, k % DY), k == last_idx);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        $display("frame: pattern=%0d pixels=%0d last_at=%0d random_valid=%0d t=%0t",
                 pat, npx, last_idx, rnd, $time);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (conv_enable !== 1'b0) begin bad++; $display("FAIL reset_conv_enable: got %b want 0", conv_enable); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
        total++; if (buf_errs(3, 0, NPX - 1) != 0) begin bad++; $display("FAIL reset_buffer: got %0d nonzero entries want 0", buf_errs(3, 0, NPX - 1)); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        int ce0 = ce_cnt;
        int fd0 = fd_cnt;
        send_frame(0, NPX, NPX - 1, 1'b0);
        total++; if (conv_enable !== 1'b1) begin bad++; $display("FAIL frame_conv_latency: got %b want 1", conv_enable); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL frame_ready_in_conv: got %b want 0", pix_ready); end
        @(negedge clk);
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
        total++; if (conv_enable !== 1'b0) begin bad++; $display("FAIL frame_conv_drop: got %b want 0", conv_enable); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy_done: got %b want 1", busy); end
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
        total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL frame_rearm: got %b want 1", pix_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy_idle: got %b want 0", busy); end
        total++; if (ce_cnt - ce0 != 3) begin bad++; $display("FAIL frame_conv_cycles: got %0d want 3", ce_cnt - ce0); end
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0); end
        total++; if (buf_errs(0, 0, NPX - 1) != 0) begin bad++; $display("FAIL frame_buffer: got %0d bad entries want 0", buf_errs(0, 0, NPX - 1)); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_random_valid();
        int fd0 = fd_cnt;
        send_frame(1, NPX, NPX - 1, 1'b1);
        pix_valid = 1'b1;
        pix_data  = 8'hEE;
        total++; if (pix_ready !== 1'b0 || conv_enable !== 1'b1) begin bad++; $display("FAIL rnd_conv_entry: got ready=%b en=%b want ready=0 en=1", pix_ready, conv_enable); end
        @(negedge clk);
        conv_done = 1'b1;
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL rnd_ready_conv: got %b want 0", pix_ready); end
        @(negedge clk);
        conv_done = 1'b0;
        total++; if (pix_ready !== 1'b0 || frame_done !== 1'b1) begin bad++; $display("FAIL rnd_ready_done: got ready=%b done=%b want ready=0 done=1", pix_ready, frame_done); end
        pix_valid = 1'b0;
        @(negedge clk);
        total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rnd_rearm: got %b want 1", pix_ready); end
        total++; if (buf_errs(1, 0, NPX - 1) != 0) begin bad++; $display("FAIL rnd_buffer: got %0d bad entries want 0", buf_errs(1, 0, NPX - 1)); end
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL rnd_done_count: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_early_last();
        int ce0 = ce_cnt;
        send_frame(0, 101, 100, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", frame_err); end
        total++; if (busy !== 1'b0 || pix_ready !== 1'b1) begin bad++; $display("FAIL early_resync: got busy=%b ready=%b want busy=0 ready=1", busy, pix_ready); end
        total++; if (ce_cnt - ce0 != 0) begin bad++; $display("FAIL early_no_conv: got %0d enable cycles want 0", ce_cnt - ce0); end
        total++; if (buf_errs(0, 0, 99) != 0) begin bad++; $display("FAIL early_partial: got %0d bad entries want 0", buf_errs(0, 0, 99)); end
        total++; if (dut_data[3][16] !== pixfn(1, 3, 16)) begin bad++; $display("FAIL early_discard: got %0d want %0d", dut_data[3][16], pixfn(1, 3, 16)); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL early_err_clr: got %b want 0", frame_err); end
        send_frame(2, NPX, NPX - 1, 1'b0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        @(negedge clk);
        total++; if (buf_errs(2, 0, NPX - 1) != 0) begin bad++; $display("FAIL early_next_frame: got %0d bad entries want 0", buf_errs(2, 0, NPX - 1)); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL early_next_err: got %b want 0", frame_err); end
    endtask

    task automatic test_timeout();
        int ce0 = ce_cnt;
        int fd0 = fd_cnt;
        send_frame(0, NPX, NPX - 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (ce_cnt - ce0 != TMO) begin bad++; $display("FAIL tmo_conv_cycles: got %0d want %0d", ce_cnt - ce0, TMO); end
        total++; if (fd_cnt - fd0 != 0) begin bad++; $display("FAIL tmo_no_done: got %0d want 0", fd_cnt - fd0); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", frame_err); end
        total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL tmo_back_to_load: got %b want 1", pix_ready); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL tmo_err_clr: got %b want 0", frame_err); end
        // conv_done arriving on the timeout edge must complete the frame normally
        ce0 = ce_cnt;
        fd0 = fd_cnt;
        send_frame(2, NPX, NPX - 1, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        total++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL tmo_done_wins: got done=%b err=%b want done=1 err=0", frame_done, frame_err); end
        @(negedge clk);
        total++; if (ce_cnt - ce0 != TMO) begin bad++; $display("FAIL tmo_edge_cycles: got %0d want %0d", ce_cnt - ce0, TMO); end
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL tmo_edge_done: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_async_reset();
        send_frame(1, 400, -1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_busy_before: got %b want 1", busy); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        total++; if (conv_enable !== 1'b0) begin bad++; $display("FAIL arst_conv_enable: got %b want 0", conv_enable); end
        total++; if (buf_errs(3, 0, NPX - 1) != 0) begin bad++; $display("FAIL arst_buffer: got %0d nonzero entries want 0", buf_errs(3, 0, NPX - 1)); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, NPX, NPX - 1, 1'b0);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        @(negedge clk);
        total++; if (buf_errs(0, 0, NPX - 1) != 0) begin bad++; $display("FAIL arst_next_frame: got %0d bad entries want 0", buf_errs(0, 0, NPX - 1)); end
    endtask

    task automatic test_missing_last();
        int fd0 = fd_cnt;
        // err_clr is held through the frame: the set on the final pixel must still win
        err_clr = 1'b1;
        send_frame(2, NPX, -1, 1'b0);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL nolast_err: got %b want 1", frame_err); end
        total++; if (conv_enable !== 1'b1) begin bad++; $display("FAIL nolast_conv: got %b want 1", conv_enable); end
        err_clr = 1'b0;
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        @(negedge clk);
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL nolast_done: got %0d want 1", fd_cnt - fd0); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL nolast_err_sticky: got %b want 1", frame_err); end
        total++; if (buf_errs(2, 0, NPX - 1) != 0) begin bad++; $display("FAIL nolast_buffer: got %0d bad entries want 0", buf_errs(2, 0, NPX - 1)); end
        total++; if (stall_err !== 1'b0) begin bad++; $display("FAIL handshake_stall: got %b want 0", stall_err); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random_valid();
        test_early_last();
        test_timeout();
        test_async_reset();
        test_missing_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
